div_operand_sequencer: RTL
==========================

Name: div_operand_sequencer

Overview:
Upstream front end for the fixed-point divider. It buffers operand pairs (A, B) in a small FIFO and drives the divider's ld_a/ld_b/start protocol one job at a time. It collects q/ov into a valid/ready result port. Divide-by-zero is short-circuited without using the divider, and a hung divider is caught by a watchdog timeout.

Parameters:
W, 10, operand/quotient width (fixed-point, same format as divider)
DEPTH, 4, operand FIFO entries (power of two, >=2)
TIMEOUT, 64, max cycles waited for div_done after div_start

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair offered
in_ready  output  1  FIFO can accept (= !full)
in_a  input  W  dividend
in_b  input  W  divisor
div_a  output  W  registered dividend to divider A
div_b  output  W  registered divisor to divider B
div_ld_a  output  1  one-cycle load pulse for A
div_ld_b  output  1  one-cycle load pulse for B
div_start  output  1  one-cycle start pulse
div_done  input  1  divider result valid (sampled in WAIT only)
div_q  input  W  divider quotient
div_ov  input  1  divider overflow
out_valid  output  1  result held valid
out_ready  input  1  consumer accepts result
out_q  output  W  quotient
out_ov  output  1  overflow / div-by-zero / timeout
out_err  output  1  1 only for timeout results
busy  output  1  state != IDLE or FIFO non-empty
fifo_count  output  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (synchronous, active-high) clears state to IDLE, FIFO pointers and count to 0, and the timer to 0. All outputs go to 0 except in_ready=1. rst wins over every other event. A job in progress at reset is dropped, and no result is produced for it.
- FIFO push: in_valid && in_ready. Pop: done by the FSM in IDLE. Push and pop in the same cycle leave the count unchanged. When full, in_ready=0, even if a pop occurs that cycle. Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, START, WAIT, OUT.
- IDLE: if count>0, pop the head and register div_a and div_b.
  - If the head's B==0: out_q=all ones, out_ov=1, out_err=0, and go to OUT.
  - Otherwise go to LOAD.
- LOAD: div_ld_a=div_ld_b=1 for exactly one cycle, then START.
- START: div_start=1 for exactly one cycle. Timer cleared. Go to WAIT.
- WAIT: timer increments each cycle.
  - If div_done=1: capture out_q=div_q, out_ov=div_ov, out_err=0, and go to OUT.
  - Else if the timer reaches TIMEOUT-1: out_q=0, out_ov=1, out_err=1, and go to OUT.
  - div_done takes priority over timeout in the same cycle.
- OUT: out_valid=1. out_q, out_ov and out_err are stable until the handshake. On out_ready, go to IDLE with out_valid=0 on the next cycle. No back-to-back results: at least one IDLE cycle between jobs.
- div_a and div_b stay stable from LOAD through the end of WAIT. div_ld_a, div_ld_b and div_start are 0 in all other states.
- Latency for a push at edge k into an empty FIFO with the FSM in IDLE:
  - pop at edge k+1;
  - div_ld high during k+1..k+2;
  - div_start high during k+2..k+3;
  - done seen in the first WAIT cycle gives out_valid high after edge k+4.
  - Zero divisor gives out_valid high after edge k+1.
- Results are delivered in FIFO order. Pushes continue while the FSM is busy.

Test Plan:
- Basic: push A=10'b0000100000, B=10'b0000010000. Bench divider model returns q=10'b0001000000, ov=0, one cycle after start. Required: exactly one ld pulse, then one start pulse, div_a/div_b equal to the inputs, out_q=0x040, out_ov=0, out_valid after edge k+4.
- Divide by zero: push A=0x0F0, B=0. Required: no ld or start pulses, out_q=0x3FF, out_ov=1, out_err=0, out_valid after edge k+1.
- FIFO full/backpressure: hold out_ready=0 and push 6 pairs. Required: in_ready drops after 4 accepted (fifo_count=4) plus the one in flight. Releasing out_ready drains results in push order.
- Timeout: the model never asserts div_done. Required: after TIMEOUT cycles in WAIT, out_q=0, out_ov=1, out_err=1. The next job then proceeds normally.
- Done versus timeout: assert div_done exactly on the TIMEOUT-1 cycle. Required: the divider result is taken and out_err=0.
- Reset mid-job: assert rst during WAIT with 2 entries queued. Required: the next cycle shows IDLE, fifo_count=0, out_valid=0, in_ready=1, and no stale result appears.

Source files
------------

// File: rtl/div_operand_sequencer.sv
// Front end for the fixed-point divider: queues operand pairs, runs one divide at a time
// through the ld/start handshake, and returns results on a valid/ready port.
module div_operand_sequencer #(
    parameter int W       = 10,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    output logic [W-1:0]             div_a,
    output logic [W-1:0]             div_b,
    output logic                     div_ld_a,
    output logic                     div_ld_b,
    output logic                     div_start,
    input  logic                     div_done,
    input  logic [W-1:0]             div_q,
    input  logic                     div_ov,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_q,
    output logic                     out_ov,
    output logic                     out_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_OUT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_mem_a [DEPTH];
    logic [W-1:0]    r_mem_b [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [TW-1:0]   r_timer;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_head_zero;
    logic            w_timeout;

    assign w_full      = (r_count == (AW+1)'(DEPTH));
    assign w_push      = in_valid && !w_full;
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_head_zero = (r_mem_b[r_rd_ptr] == '0);
    assign w_timeout   = (r_timer == TW'(TIMEOUT - 1));

    assign in_ready   = !w_full;
    assign fifo_count = r_count;
    assign busy       = (r_state != S_IDLE) || (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        div_ld_a  = 1'b0;
        div_ld_b  = 1'b0;
        div_start = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pop) w_next = w_head_zero ? S_OUT : S_LOAD;
            end
            S_LOAD: begin
                div_ld_a = 1'b1;
                div_ld_b = 1'b1;
                w_next   = S_START;
            end
            S_START: begin
                div_start = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (div_done || w_timeout) w_next = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand and result registers only move on state transitions, so they hold steady
    // across LOAD..WAIT and for the whole OUT handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_a   <= '0;
            div_b   <= '0;
            out_q   <= '0;
            out_ov  <= 1'b0;
            out_err <= 1'b0;
            r_timer <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        div_a <= r_mem_a[r_rd_ptr];
                        div_b <= r_mem_b[r_rd_ptr];
                        if (w_head_zero) begin
                            out_q   <= '1;
                            out_ov  <= 1'b1;
                            out_err <= 1'b0;
                        end
                    end
                end
                S_START: r_timer <= '0;
                S_WAIT: begin
                    if (div_done) begin
                        out_q   <= div_q;
                        out_ov  <= div_ov;
                        out_err <= 1'b0;
                    end else if (w_timeout) begin
                        out_q   <= '0;
                        out_ov  <= 1'b1;
                        out_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
